// File: rtl/nibble_serial_adder.sv
// Sequences a W-bit add through an external 4-bit ripple adder, one nibble per clock.
// Define SUB_EN to add the sub port and the a - b path.
module nibble_serial_adder #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic [3:0]   na,
    output logic [3:0]   nb,
    output logic         ncin,
    input  logic [3:0]   nsum,
    input  logic         ncout
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          accept;
    logic          last;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    b_inv;
    logic          carry_init;

`ifdef SUB_EN
    logic sub_q, sub_d;
    // Subtraction is a + ~b + 1, so the initial carry replaces cin.
    assign b_inv      = {4{sub_q}};
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign b_inv      = 4'b0000;
    assign carry_init = cin;
`endif

    assign accept = start && (state_q != RUN);
    assign last   = (k_q == KW'(NIBBLES - 1));

    always_comb begin
        a_nib = 4'b0000;
        b_nib = 4'b0000;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k_q == KW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (k_q == KW'(i)) sum_d[4*i +: 4] = nsum;
                end
                carry_d = ncout;
                k_d     = k_q + KW'(1);
                if (last) begin
                    cout_d  = ncout;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = accept ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d     = a;
            b_d     = b;
            k_d     = '0;
            carry_d = carry_init;
            sum_d   = '0;
            cout_d  = 1'b0;
`ifdef SUB_EN
            sub_d   = sub;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign na   = busy ? a_nib : 4'b0000;
    assign nb   = busy ? (b_nib ^ b_inv) : 4'b0000;
    assign ncin = busy & carry_q;

endmodule
